// File: rtl/data_memory_access_unit.sv
// data_memory_access_unit: sequences address/write/read strobes to the memory manager for one load or store request
module data_memory_access_unit #(
  parameter int         READ_LATENCY     = 1,
  parameter logic [9:0] INPUT_PORT_ADDR  = 10'h3FE,
  parameter logic [9:0] OUTPUT_PORT_ADDR = 10'h3FF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_req,
  input  logic       in_we,
  input  logic [9:0] in_addr,
  input  logic [7:0] in_wdata,
  output logic       out_ack,
  output logic [7:0] out_rdata,
  output logic       out_error,
  output logic       out_busy,
  output logic [9:0] out_mem_addr,
  output logic       out_mem_addr_write_en,
  output logic       out_mem_write_en,
  output logic       out_mem_read_en,
  output logic [7:0] out_mem_data,
  input  logic [7:0] in_mem_data
);
  typedef enum logic [2:0] {IDLE, ADDR, WRITE, READ, CAPTURE, DONE} state_t;
  state_t state, next;
  logic       we_q;
  logic [7:0] wdata_q;
  logic [2:0] cnt;
  logic       illegal;
  assign illegal = in_we ? in_addr == INPUT_PORT_ADDR : in_addr == OUTPUT_PORT_ADDR;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next;
  always_comb begin
    next = state == IDLE    ? (in_req ? (illegal ? DONE : ADDR) : IDLE) :
           state == ADDR    ? (we_q ? WRITE : READ) :
           state == WRITE   ? DONE :
           state == READ    ? (cnt == 3'd0 ? CAPTURE : READ) :
           state == CAPTURE ? DONE : IDLE;
  end
  // Strobes are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_q                  <= 1'b0;
      wdata_q               <= '0;
      cnt                   <= '0;
      out_mem_addr          <= '0;
      out_mem_data          <= '0;
      out_rdata             <= '0;
      out_mem_addr_write_en <= 1'b0;
      out_mem_write_en      <= 1'b0;
      out_mem_read_en       <= 1'b0;
      out_ack               <= 1'b0;
      out_error             <= 1'b0;
      out_busy              <= 1'b0;
    end else begin
      if (state == IDLE && in_req) begin
        we_q    <= in_we;
        wdata_q <= in_wdata;
      end
      if (next == ADDR) out_mem_addr <= in_addr;
      cnt                   <= state == ADDR ? 3'(READ_LATENCY - 1) : state == READ ? cnt - 3'd1 : cnt;
      out_mem_data          <= next == WRITE ? wdata_q : out_mem_data;
      out_rdata             <= state == CAPTURE ? in_mem_data : out_rdata;
      out_mem_addr_write_en <= next == ADDR;
      out_mem_write_en      <= next == WRITE;
      out_mem_read_en       <= next == READ || next == CAPTURE;
      out_ack               <= next == DONE;
      out_error             <= next == DONE && state == IDLE;
      out_busy              <= next != IDLE;
    end
endmodule
